rx_word_align: RTL and testbench

- Word-alignment stage directly downstream of the RX IOD bit-alignment controller on each sub-LVDS/LVDS camera lane.
- Starts once bit alignment reports done without error.
- Searches the deserialized parallel words for a repeating training pattern and locks the word boundary (barrel-shift offset).
- Delivers aligned words to the lane deskew/pixel unpacker; on timeout, requests a bit-alignment restart.

---
 rtl/rx_align_pkg.sv | 24 ++
 rtl/rx_word_barrel_shift.sv | 26 ++
 rtl/rx_word_align.sv | 164 ++++++++++++++++
 tb/tb_rx_word_align.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/rx_align_pkg.sv
// Shared state type, default lane constants and the rotation matcher for the RX word aligner.
package rx_align_pkg;

   localparam int               RX_DW    = 8;
   localparam logic [RX_DW-1:0] RX_TRAIN = 8'hB5;

   typedef enum logic [2:0] {
      IDLE,
      SEARCH,
      CONFIRM,
      LOCKED,
      FAIL
   } align_state_t;

   // Bit k is set when the word starting at bit k of the two-word window equals the pattern.
   function automatic logic [RX_DW-1:0] rot_match(input logic [2*RX_DW-1:0] window,
                                                  input logic [RX_DW-1:0]   pattern);
      logic [RX_DW-1:0] mv;
      for (int k = 0; k < RX_DW; k++)
         mv[k] = (window[k +: RX_DW] == pattern);
      return mv;
   endfunction

endpackage

// File: rtl/rx_word_barrel_shift.sv
// Two-word history window with a candidate mux selecting the word that starts at bit sel.
// One register stage; the window only advances on valid words.
module rx_word_barrel_shift
   import rx_align_pkg::*;
#(
   parameter int W = RX_DW
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [W-1:0]         data,
   input  logic                 valid,
   input  logic [$clog2(W)-1:0] sel,
   output logic [2*W-1:0]       window,
   output logic [W-1:0]         cand
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         window <= '0;
      else if (valid)
         window <= {data, window[2*W-1:W]};
   end

   assign cand = window[sel +: W];

endmodule

// File: rtl/rx_word_align.sv
// Locks the word boundary on a repeating training pattern once bit alignment is done, then
// delivers aligned words two register stages behind the input; no backpressure, words only qualified while locked.
module rx_word_align
   import rx_align_pkg::*;
#(
   parameter int                    DATA_WIDTH    = RX_DW,
   parameter logic [DATA_WIDTH-1:0] TRAIN_PATTERN = RX_TRAIN,
   parameter int                    MATCH_CNT     = 16,
   parameter int                    TIMEOUT_WORDS = 1024,
   parameter int                    MAX_RETRY     = 3
) (
   input  logic                          SCLK,
   input  logic                          RESET,
   input  logic                          BIT_ALGN_DONE,
   input  logic                          BIT_ALGN_ERR,
   input  logic [DATA_WIDTH-1:0]         RX_DATA_IN,
   input  logic                          RX_DATA_VALID,
   input  logic                          WORD_ALGN_RSTRT,
   output logic [DATA_WIDTH-1:0]         RX_DATA_OUT,
   output logic                          RX_DATA_OUT_VALID,
   output logic                          WORD_ALGN_DONE,
   output logic                          WORD_ALGN_ERR,
   output logic [$clog2(DATA_WIDTH)-1:0] WORD_ALGN_OFFSET,
   output logic                          BIT_ALGN_RSTRT
);

   localparam int OW = $clog2(DATA_WIDTH);
   localparam int MW = $clog2(MATCH_CNT + 1);
   localparam int TW = $clog2(TIMEOUT_WORDS + 1);
   localparam int RW = $clog2(MAX_RETRY + 1);

   align_state_t            state, state_nxt;
   logic [OW-1:0]           offset, offset_nxt, lowest;
   logic [MW-1:0]           match_cnt, match_nxt;
   logic [TW-1:0]           to_cnt, to_nxt;
   logic [RW-1:0]           retry, retry_nxt;
   logic [1:0]              fill, fill_nxt;
   logic                    done_d, armed, start, abort, timeout;
   logic                    rstrt, rstrt_nxt, out_vld, out_vld_nxt;
   logic [2*DATA_WIDTH-1:0] window;
   logic [DATA_WIDTH-1:0]   cand, match_vec, data_out;

   rx_word_barrel_shift #(.W(DATA_WIDTH)) u_shift (
      .clk    (SCLK),
      .rst    (RESET),
      .data   (RX_DATA_IN),
      .valid  (RX_DATA_VALID),
      .sel    (offset),
      .window (window),
      .cand   (cand)
   );

   assign match_vec = rot_match(window, TRAIN_PATTERN);
   // armed stays low until DONE is seen low, so a level already high at reset release is ignored
   assign start     = BIT_ALGN_DONE && !done_d && armed && !BIT_ALGN_ERR;
   assign abort     = (state inside {SEARCH, CONFIRM, LOCKED}) && (!BIT_ALGN_DONE || BIT_ALGN_ERR);
   assign timeout   = RX_DATA_VALID && (to_cnt >= TW'(TIMEOUT_WORDS - 1));

   always_comb begin
      lowest = '0;
      for (int k = DATA_WIDTH - 1; k >= 0; k--)
         if (match_vec[k]) lowest = OW'(k);
   end

   always_comb begin
      state_nxt  = state;
      offset_nxt = offset;
      match_nxt  = match_cnt;
      to_nxt     = to_cnt;
      retry_nxt  = retry;
      fill_nxt   = fill;
      rstrt_nxt  = 1'b0;
      if (WORD_ALGN_RSTRT) begin
         state_nxt = IDLE;
         match_nxt = '0;
         to_nxt    = '0;
         retry_nxt = '0;
         fill_nxt  = '0;
      end else if (abort) begin
         state_nxt = IDLE;
         match_nxt = '0;
         fill_nxt  = '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state_nxt = SEARCH;
                  match_nxt = '0;
                  to_nxt    = '0;
                  fill_nxt  = '0;
               end
            end
            SEARCH, CONFIRM: begin
               if (RX_DATA_VALID) begin
                  if (to_cnt != TW'(TIMEOUT_WORDS)) to_nxt = to_cnt + TW'(1);
                  if (timeout) begin
                     if (retry < RW'(MAX_RETRY)) begin
                        state_nxt = IDLE;
                        retry_nxt = retry + RW'(1);
                        rstrt_nxt = 1'b1;
                     end else begin
                        state_nxt = FAIL;
                     end
                  end else if (state == SEARCH) begin
                     // the window must hold two words received since entry before it is trusted
                     if (fill != 2'd2) begin
                        fill_nxt = fill + 2'd1;
                     end else if (|match_vec) begin
                        offset_nxt = lowest;
                        match_nxt  = MW'(1);
                        state_nxt  = CONFIRM;
                     end
                  end else if (match_vec[offset]) begin
                     if (match_cnt != MW'(MATCH_CNT)) match_nxt = match_cnt + MW'(1);
                     if (match_cnt >= MW'(MATCH_CNT - 1)) state_nxt = LOCKED;
                  end else begin
                     match_nxt = '0;
                     state_nxt = SEARCH;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign out_vld_nxt = RX_DATA_VALID && (state == LOCKED) && (state_nxt == LOCKED);

   always_ff @(posedge SCLK or posedge RESET) begin
      if (RESET) begin
         state     <= IDLE;
         offset    <= '0;
         match_cnt <= '0;
         to_cnt    <= '0;
         retry     <= '0;
         fill      <= '0;
         done_d    <= 1'b0;
         armed     <= 1'b0;
         rstrt     <= 1'b0;
         out_vld   <= 1'b0;
         data_out  <= '0;
      end else begin
         state     <= state_nxt;
         offset    <= offset_nxt;
         match_cnt <= match_nxt;
         to_cnt    <= to_nxt;
         retry     <= retry_nxt;
         fill      <= fill_nxt;
         done_d    <= BIT_ALGN_DONE;
         armed     <= armed | ~BIT_ALGN_DONE;
         rstrt     <= rstrt_nxt;
         out_vld   <= out_vld_nxt;
         if (RX_DATA_VALID) data_out <= cand;
      end
   end

   assign RX_DATA_OUT       = data_out;
   assign RX_DATA_OUT_VALID = out_vld;
   assign WORD_ALGN_DONE    = (state == LOCKED);
   assign WORD_ALGN_ERR     = (state == FAIL);
   assign WORD_ALGN_OFFSET  = offset;
   assign BIT_ALGN_RSTRT    = rstrt;

endmodule

// File: tb/tb_rx_word_align.sv
// Directed bench for rx_word_align: lock at several offsets, relock after corruption,
// timeout/retry/fail, stale DONE, DONE drop, async reset and sparse valid.
module tb_rx_word_align;

   logic       sclk = 1'b0;
   logic       rst, bit_done, bit_err, valid, wa_rstrt;
   logic [7:0] din, dout;
   logic       dout_vld, wa_done, wa_err, ba_rstrt;
   logic [2:0] wa_off;
   int         n_checks = 0;
   int         n_fail = 0;

   always #5 sclk = ~sclk;

   rx_word_align dut (
      .SCLK              (sclk),
      .RESET             (rst),
      .BIT_ALGN_DONE     (bit_done),
      .BIT_ALGN_ERR      (bit_err),
      .RX_DATA_IN        (din),
      .RX_DATA_VALID     (valid),
      .WORD_ALGN_RSTRT   (wa_rstrt),
      .RX_DATA_OUT       (dout),
      .RX_DATA_OUT_VALID (dout_vld),
      .WORD_ALGN_DONE    (wa_done),
      .WORD_ALGN_ERR     (wa_err),
      .WORD_ALGN_OFFSET  (wa_off),
      .BIT_ALGN_RSTRT    (ba_rstrt)
   );

   function automatic logic [7:0] rol8(input logic [7:0] v, input int k);
      return (v << k) | (v >> (8 - k));
   endfunction

   task automatic send(input logic [7:0] w, input logic v);
      din = w; valid = v;
      @(posedge sclk); #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; bit_done = 1'b0; bit_err = 1'b0; valid = 1'b0; din = 8'h00; wa_rstrt = 1'b0;
      repeat (2) @(posedge sclk);
      #1;
      n_checks++; if (wa_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", wa_done); end
      n_checks++; if (wa_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", wa_err); end
      n_checks++; if (dout_vld !== 1'b0) begin n_fail++; $display("FAIL reset_vld: got %b want 0", dout_vld); end
      n_checks++; if (ba_rstrt !== 1'b0) begin n_fail++; $display("FAIL reset_rstrt: got %b want 0", ba_rstrt); end
      n_checks++; if (wa_off !== 3'd0) begin n_fail++; $display("FAIL reset_off: got %0d want 0", wa_off); end
      n_checks++; if (dout !== 8'h00) begin n_fail++; $display("FAIL reset_dout: got %h want 00", dout); end
      rst = 1'b0;
   endtask

   task automatic test_stale_done();
      logic seen;
      rst = 1'b1; bit_done = 1'b1;
      @(posedge sclk); #1;
      rst = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 30; i++) begin
         send(8'hB5, 1'b1);
         if (wa_done) seen = 1'b1;
      end
      n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL stale_done_lock: locked=%b want 0", seen); end
      bit_done = 1'b0; send(8'hB5, 1'b1);
      bit_done = 1'b1; send(8'hB5, 1'b1);
      for (int i = 1; i < 18; i++) send(8'hB5, 1'b1);
      n_checks++; if (wa_done !== 1'b0) begin n_fail++; $display("FAIL stale_rearm_early: got %b want 0", wa_done); end
      send(8'hB5, 1'b1);
      n_checks++; if (wa_done !== 1'b1) begin n_fail++; $display("FAIL stale_rearm_lock: got %b want 1", wa_done); end
   endtask

   task automatic test_lock(input int k);
      logic [7:0]  w, p, exp;
      logic [15:0] t;
      w = rol8(8'hB5, k);
      p = 8'h3C;
      bit_done = 1'b0; send(w, 1'b1); send(w, 1'b1);
      bit_done = 1'b1; send(w, 1'b1);
      for (int i = 1; i < 18; i++) send(w, 1'b1);
      n_checks++; if (wa_done !== 1'b0) begin n_fail++; $display("FAIL lock_early_k%0d: got %b want 0", k, wa_done); end
      send(w, 1'b1);
      n_checks++; if (wa_done !== 1'b1) begin n_fail++; $display("FAIL lock_done_k%0d: got %b want 1", k, wa_done); end
      n_checks++; if (wa_off !== 3'(k)) begin n_fail++; $display("FAIL lock_off_k%0d: got %0d want %0d", k, wa_off, k); end
      send(p, 1'b1);
      n_checks++; if ({dout_vld, dout} !== {1'b1, 8'hB5}) begin n_fail++; $display("FAIL lock_out0_k%0d: got vld=%b %h want vld=1 b5", k, dout_vld, dout); end
      send(p, 1'b1);
      t = {p, w}; t = t >> k; exp = t[7:0];
      n_checks++; if (dout !== exp) begin n_fail++; $display("FAIL lock_out1_k%0d: got %h want %h", k, dout, exp); end
      send(p, 1'b1);
      t = {p, p}; t = t >> k; exp = t[7:0];
      n_checks++; if (dout !== exp) begin n_fail++; $display("FAIL lock_out2_k%0d: got %h want %h", k, dout, exp); end
   endtask

   task automatic test_done_drop();
      bit_done = 1'b0;
      send(8'h3C, 1'b1);
      n_checks++; if (wa_done !== 1'b0) begin n_fail++; $display("FAIL drop_done: got %b want 0", wa_done); end
      n_checks++; if (dout_vld !== 1'b0) begin n_fail++; $display("FAIL drop_vld: got %b want 0", dout_vld); end
   endtask

   task automatic test_corrupt();
      logic [7:0] w;
      logic       seen;
      w = rol8(8'hB5, 3);
      bit_done = 1'b0; send(w, 1'b1); send(w, 1'b1);
      bit_done = 1'b1; send(w, 1'b1);
      for (int i = 1; i <= 12; i++) send(w, 1'b1);
      send(8'h00, 1'b1);
      seen = 1'b0;
      for (int i = 14; i <= 30; i++) begin
         send(w, 1'b1);
         if (dout_vld || wa_done) seen = 1'b1;
      end
      n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL corrupt_early_lock: got %b want 0", seen); end
      send(w, 1'b1);
      n_checks++; if (wa_done !== 1'b1) begin n_fail++; $display("FAIL corrupt_relock: got %b want 1", wa_done); end
      n_checks++; if (wa_off !== 3'd3) begin n_fail++; $display("FAIL corrupt_off: got %0d want 3", wa_off); end
      send(w, 1'b1);
      n_checks++; if (dout_vld !== 1'b1) begin n_fail++; $display("FAIL corrupt_vld: got %b want 1", dout_vld); end
   endtask

   task automatic test_sparse_valid();
      logic [7:0]  w, p, exp;
      logic [15:0] t;
      w = rol8(8'hB5, 4);
      p = 8'h96;
      bit_done = 1'b0; send(w, 1'b1); send(w, 1'b1);
      bit_done = 1'b1; send(w, 1'b1);
      for (int i = 1; i <= 17; i++) begin
         send(w, 1'b1); send(8'hFF, 1'b0); send(8'h00, 1'b0);
      end
      n_checks++; if (wa_done !== 1'b0) begin n_fail++; $display("FAIL sparse_early: got %b want 0", wa_done); end
      send(w, 1'b1);
      n_checks++; if (wa_done !== 1'b1) begin n_fail++; $display("FAIL sparse_lock: got %b want 1", wa_done); end
      n_checks++; if (wa_off !== 3'd4) begin n_fail++; $display("FAIL sparse_off: got %0d want 4", wa_off); end
      send(p, 1'b1);
      n_checks++; if ({dout_vld, dout} !== {1'b1, 8'hB5}) begin n_fail++; $display("FAIL sparse_out0: got vld=%b %h want vld=1 b5", dout_vld, dout); end
      send(8'hE7, 1'b0);
      n_checks++; if ({dout_vld, dout} !== {1'b0, 8'hB5}) begin n_fail++; $display("FAIL sparse_hold: got vld=%b %h want vld=0 b5", dout_vld, dout); end
      send(p, 1'b1);
      t = {p, w}; t = t >> 4; exp = t[7:0];
      n_checks++; if ({dout_vld, dout} !== {1'b1, exp}) begin n_fail++; $display("FAIL sparse_out1: got vld=%b %h want vld=1 %h", dout_vld, dout, exp); end
   endtask

   task automatic test_reset_mid_confirm();
      logic [7:0] w;
      w = rol8(8'hB5, 5);
      bit_done = 1'b0; send(w, 1'b1); send(w, 1'b1);
      bit_done = 1'b1; send(w, 1'b1);
      for (int i = 1; i <= 8; i++) send(w, 1'b1);
      n_checks++; if (wa_off !== 3'd5) begin n_fail++; $display("FAIL midrst_pre_off: got %0d want 5", wa_off); end
      #2 rst = 1'b1;
      #1;
      n_checks++; if (wa_off !== 3'd0) begin n_fail++; $display("FAIL midrst_off: got %0d want 0", wa_off); end
      n_checks++; if (dout !== 8'h00) begin n_fail++; $display("FAIL midrst_dout: got %h want 00", dout); end
      n_checks++; if ({dout_vld, wa_done, wa_err, ba_rstrt} !== 4'b0000) begin n_fail++; $display("FAIL midrst_flags: got %b want 0000", {dout_vld, wa_done, wa_err, ba_rstrt}); end
      @(posedge sclk); #1;
      rst = 1'b0;
   endtask

   task automatic test_timeout();
      logic seen;
      wa_rstrt = 1'b1; send(8'h00, 1'b0);
      wa_rstrt = 1'b0;
      for (int r = 0; r < 4; r++) begin
         bit_done = 1'b0; send(8'($urandom), 1'b1); send(8'($urandom), 1'b1);
         bit_done = 1'b1; send(8'($urandom), 1'b1);
         seen = 1'b0;
         for (int i = 1; i < 1024; i++) begin
            send(8'($urandom), 1'b1);
            if (ba_rstrt || wa_err) seen = 1'b1;
         end
         n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL timeout_early_r%0d: got %b want 0", r, seen); end
         send(8'($urandom), 1'b1);
         if (r < 3) begin
            n_checks++; if ({ba_rstrt, wa_err} !== 2'b10) begin n_fail++; $display("FAIL timeout_retry_r%0d: rstrt/err got %b want 10", r, {ba_rstrt, wa_err}); end
         end else begin
            n_checks++; if ({ba_rstrt, wa_err} !== 2'b01) begin n_fail++; $display("FAIL timeout_fail: rstrt/err got %b want 01", {ba_rstrt, wa_err}); end
         end
         send(8'($urandom), 1'b1);
         n_checks++; if (ba_rstrt !== 1'b0) begin n_fail++; $display("FAIL timeout_pulse_r%0d: got %b want 0", r, ba_rstrt); end
      end
      bit_done = 1'b0;
      repeat (3) send(8'($urandom), 1'b1);
      n_checks++; if (wa_err !== 1'b1) begin n_fail++; $display("FAIL fail_hold: got %b want 1", wa_err); end
      wa_rstrt = 1'b1; send(8'($urandom), 1'b1);
      wa_rstrt = 1'b0;
      n_checks++; if (wa_err !== 1'b0) begin n_fail++; $display("FAIL fail_clear: got %b want 0", wa_err); end
   endtask

   initial begin
      test_reset();
      test_stale_done();
      test_lock(0);
      test_lock(2);
      test_lock(5);
      test_lock(7);
      test_done_drop();
      test_corrupt();
      test_sparse_valid();
      test_reset_mid_confirm();
      test_timeout();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
